// File: rtl/simd_mac_pkg.sv
// Shared definitions for the SIMD multiply-accumulate: mode encodings, lane counts
// and the lane-width helper used to size the per-mode multipliers.
package simd_mac_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_SUM4 = 2'b01,
    MODE_SUM8 = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int LANES_FULL = 32'sd1;
  localparam int LANES_SUM4 = 32'sd4;
  localparam int LANES_SUM8 = 32'sd8;

  // FULL (and reserved, which executes as FULL) uses a half-width lane.
  function automatic int lane_width(input int data_w, input mode_e m);
    case (m)
      MODE_SUM4: lane_width = data_w / LANES_SUM4;
      MODE_SUM8: lane_width = data_w / LANES_SUM8;
      default:   lane_width = data_w / 32'sd2;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_mult.sv
// One Q x Q lane multiplier with independent signedness per operand; the 2Q-bit
// product is exact for every sign combination, so the low 2Q bits of a 2Q-wide multiply suffice.
module simd_lane_mult #(
  parameter int Q = 8
) (
  input  logic [Q-1:0]   a,
  input  logic [Q-1:0]   b,
  input  logic           a_sign,
  input  logic           b_sign,
  output logic [2*Q-1:0] prod
);

  logic [2*Q-1:0] a_wide_s;
  logic [2*Q-1:0] b_wide_s;

  assign a_wide_s = {{Q{a_sign & a[Q-1]}}, a};
  assign b_wide_s = {{Q{b_sign & b[Q-1]}}, b};
  assign prod     = a_wide_s * b_wide_s;

endmodule

// File: rtl/simd_mac_pipelined.sv
// 3-stage precision-configurable SIMD MAC (operand regs, lane products, sum+accumulate).
// Build macro MAC_SAT_EN: when defined the accumulator saturates on overflow instead of wrapping.
module simd_mac_pipelined
  import simd_mac_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [1:0]        mode,
  input  logic              first,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              result_ovf,
  output logic              mode_err
);

  localparam int QF = lane_width(DATA_W, MODE_FULL);
  localparam int Q4 = lane_width(DATA_W, MODE_SUM4);
  localparam int Q8 = lane_width(DATA_W, MODE_SUM8);

  logic              stall_s;

  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;
  logic              s1_a_sign_r;
  logic              s1_b_sign_r;
  mode_e             s1_mode_r;
  logic              s1_first_r;
  logic              s1_last_r;

  logic [2*QF-1:0]   pf_s [LANES_FULL];
  logic [2*Q4-1:0]   p4_s [LANES_SUM4];
  logic [2*Q8-1:0]   p8_s [LANES_SUM8];

  logic              s2_valid_r;
  logic [2*QF-1:0]   s2_pf_r [LANES_FULL];
  logic [2*Q4-1:0]   s2_p4_r [LANES_SUM4];
  logic [2*Q8-1:0]   s2_p8_r [LANES_SUM8];
  mode_e             s2_mode_r;
  logic              s2_sgn_r;
  logic              s2_first_r;
  logic              s2_last_r;

  logic [ACC_W-1:0]  dot_s;
  logic [ACC_W-1:0]  acc_base_s;
  logic [ACC_W:0]    sum_s;
  logic              ovf_s;
  logic [ACC_W-1:0]  acc_next_s;
  logic              grp_ovf_next_s;

  logic [ACC_W-1:0]  acc_r;
  logic              grp_ovf_r;
  logic              out_valid_r;
  logic [ACC_W-1:0]  result_r;
  logic              result_ovf_r;
  logic              mode_err_r;

  assign stall_s    = out_valid_r & ~out_ready;
  assign in_ready   = ~stall_s;
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign result_ovf = result_ovf_r;
  assign mode_err   = mode_err_r;

  // Every lane multiplier of every mode works on the S1 operands; S2 keeps them all.
  for (genvar gi = 0; gi < LANES_FULL; gi++) begin : g_full
    simd_lane_mult #(.Q(QF)) u_mult (
      .a(s1_a_r[gi*QF +: QF]), .b(s1_b_r[gi*QF +: QF]),
      .a_sign(s1_a_sign_r), .b_sign(s1_b_sign_r), .prod(pf_s[gi])
    );
  end
  for (genvar gi = 0; gi < LANES_SUM4; gi++) begin : g_sum4
    simd_lane_mult #(.Q(Q4)) u_mult (
      .a(s1_a_r[gi*Q4 +: Q4]), .b(s1_b_r[gi*Q4 +: Q4]),
      .a_sign(s1_a_sign_r), .b_sign(s1_b_sign_r), .prod(p4_s[gi])
    );
  end
  for (genvar gi = 0; gi < LANES_SUM8; gi++) begin : g_sum8
    simd_lane_mult #(.Q(Q8)) u_mult (
      .a(s1_a_r[gi*Q8 +: Q8]), .b(s1_b_r[gi*Q8 +: Q8]),
      .a_sign(s1_a_sign_r), .b_sign(s1_b_sign_r), .prod(p8_s[gi])
    );
  end

  // Lane reduction: extend each product to ACC_W by the beat's signedness and sum.
  always_comb begin
    dot_s = '0;
    case (s2_mode_r)
      MODE_SUM4: begin
        for (int i = 0; i < LANES_SUM4; i++) begin
          if (s2_sgn_r) dot_s = dot_s + ACC_W'($signed(s2_p4_r[i]));
          else          dot_s = dot_s + ACC_W'(s2_p4_r[i]);
        end
      end
      MODE_SUM8: begin
        for (int i = 0; i < LANES_SUM8; i++) begin
          if (s2_sgn_r) dot_s = dot_s + ACC_W'($signed(s2_p8_r[i]));
          else          dot_s = dot_s + ACC_W'(s2_p8_r[i]);
        end
      end
      default: begin
        for (int i = 0; i < LANES_FULL; i++) begin
          if (s2_sgn_r) dot_s = dot_s + ACC_W'($signed(s2_pf_r[i]));
          else          dot_s = dot_s + ACC_W'(s2_pf_r[i]);
        end
      end
    endcase
  end

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Accumulator update; a first beat adds onto zero so it can never overflow.
  always_comb begin
    acc_base_s = s2_first_r ? '0 : acc_r;
    sum_s      = {1'b0, acc_base_s} + {1'b0, dot_s};
    if (s2_sgn_r) begin
      ovf_s = (acc_base_s[ACC_W-1] == dot_s[ACC_W-1]) &&
              (sum_s[ACC_W-1] != acc_base_s[ACC_W-1]);
    end else begin
      ovf_s = sum_s[ACC_W];
    end
`ifdef MAC_SAT_EN
    if (!ovf_s) begin
      acc_next_s = sum_s[ACC_W-1:0];
    end else if (!s2_sgn_r) begin
      acc_next_s = '1;
    end else if (acc_base_s[ACC_W-1]) begin
      acc_next_s = SMIN;
    end else begin
      acc_next_s = SMAX;
    end
`else
    acc_next_s = sum_s[ACC_W-1:0];
`endif
    grp_ovf_next_s = (s2_first_r ? 1'b0 : grp_ovf_r) | ovf_s;
  end

  // S1 operand capture and sticky reserved-mode flag; reserved mode executes as FULL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_a_sign_r <= 1'b0;
      s1_b_sign_r <= 1'b0;
      s1_mode_r   <= MODE_FULL;
      s1_first_r  <= 1'b0;
      s1_last_r   <= 1'b0;
      mode_err_r  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r      <= a;
        s1_b_r      <= b;
        s1_a_sign_r <= a_sign;
        s1_b_sign_r <= b_sign;
        s1_mode_r   <= (mode == MODE_RSVD) ? MODE_FULL : mode_e'(mode);
        s1_first_r  <= first;
        s1_last_r   <= last;
        if (mode == MODE_RSVD) mode_err_r <= 1'b1;
      end
    end
  end

  // S2 lane-product registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_pf_r    <= '{default: '0};
      s2_p4_r    <= '{default: '0};
      s2_p8_r    <= '{default: '0};
      s2_mode_r  <= MODE_FULL;
      s2_sgn_r   <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_pf_r    <= pf_s;
        s2_p4_r    <= p4_s;
        s2_p8_r    <= p8_s;
        s2_mode_r  <= s1_mode_r;
        s2_sgn_r   <= s1_a_sign_r | s1_b_sign_r;
        s2_first_r <= s1_first_r;
        s2_last_r  <= s1_last_r;
      end
    end
  end

  // S3 accumulator and output register; a consumed result may be replaced on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r        <= '0;
      grp_ovf_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      result_r     <= '0;
      result_ovf_r <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= s2_valid_r & s2_last_r;
      if (s2_valid_r) begin
        acc_r     <= acc_next_s;
        grp_ovf_r <= s2_last_r ? 1'b0 : grp_ovf_next_s;
        if (s2_last_r) begin
          result_r     <= acc_next_s;
          result_ovf_r <= grp_ovf_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_mac_pipelined.sv
// Directed self-checking bench: dut0 uses the default 48-bit accumulator,
// dut1 uses a 32-bit accumulator for the overflow and reset-mid-group scenario.
module tb_simd_mac_pipelined;
  import simd_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        iv0, iv1, or0, or1;
  logic [31:0] a, b;
  logic        a_sign, b_sign, first, last;
  logic [1:0]  mode;
  logic        rdy0, rdy1, ov0, ov1, ovf0, ovf1, me0, me1;
  logic [47:0] res0;
  logic [31:0] res1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  simd_mac_pipelined #(.DATA_W(32), .ACC_W(48)) dut0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(rdy0), .a(a), .b(b),
    .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .first(first), .last(last),
    .out_valid(ov0), .out_ready(or0), .result(res0), .result_ovf(ovf0), .mode_err(me0)
  );

  simd_mac_pipelined #(.DATA_W(32), .ACC_W(32)) dut1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(rdy1), .a(a), .b(b),
    .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .first(first), .last(last),
    .out_valid(ov1), .out_ready(or1), .result(res1), .result_ovf(ovf1), .mode_err(me1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ov_of(input int sel);
    return (sel == 0) ? ov0 : ov1;
  endfunction

  function automatic logic [63:0] res_of(input int sel);
    return (sel == 0) ? 64'(res0) : 64'(res1);
  endfunction

  function automatic logic ovf_of(input int sel);
    return (sel == 0) ? ovf0 : ovf1;
  endfunction

  // Present one beat at a negedge, wait (bounded) for in_ready, return 1 time unit after the accepting edge.
  task automatic send(input int sel, input logic [31:0] av, input logic [31:0] bv,
                      input logic asg, input logic bsg, input logic [1:0] md,
                      input logic f, input logic l);
    int k;
    @(negedge clk);
    a = av; b = bv; a_sign = asg; b_sign = bsg; mode = md; first = f; last = l;
    if (sel == 0) iv0 = 1'b1; else iv1 = 1'b1;
    k = 0;
    while (((sel == 0) ? rdy0 : rdy1) == 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("accept_ready", (sel == 0) ? rdy0 : rdy1, 1'b1);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  // Called right after the accepting edge of a last beat: no output on edge 2, result on edge 3.
  task automatic expect_out(input int sel, input string tag, input logic [63:0] er, input logic eo);
    @(posedge clk); #1;
    check_val({tag, "_early"}, ov_of(sel), 1'b0);
    @(posedge clk); #1;
    check_val({tag, "_valid"}, ov_of(sel), 1'b1);
    check_val({tag, "_result"}, res_of(sel), er);
    check_val({tag, "_ovf"}, ovf_of(sel), eo);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    a = 32'd0; b = 32'd0; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00;
    first = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ov0", ov0, 1'b0);
    check_val("rst_res0", res0, 48'd0);
    check_val("rst_ovf0", ovf0, 1'b0);
    check_val("rst_me0", me0, 1'b0);
    check_val("rst_rdy0", rdy0, 1'b1);
    check_val("rst_ov1", ov1, 1'b0);
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;

    // 1: FULL unsigned 0xFFFF * 0xFFFF
    send(0, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    check_val("t1_lat1", ov0, 1'b0);
    expect_out(0, "t1", 64'h0000FFFE0001, 1'b0);

    // 2: SUM4 signed, -1 + 2 + 3 + 4
    send(0, 32'h040302FF, 32'h01010101, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    expect_out(0, "t2", 64'd8, 1'b0);

    // 3: SUM8 signed, 8 lanes of (-8)*(-8)
    send(0, 32'h88888888, 32'h88888888, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    expect_out(0, "t3", 64'h200, 1'b0);

    // 4: FULL signed three-beat group of (-1)*2
    send(0, 32'h0000FFFF, 32'h00000002, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    send(0, 32'h0000FFFF, 32'h00000002, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    send(0, 32'h0000FFFF, 32'h00000002, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    check_val("t4_nolast", ov0, 1'b0);
    expect_out(0, "t4", 64'hFFFFFFFFFFFA, 1'b0);
    @(posedge clk); #1;
    check_val("t4_single", ov0, 1'b0);

    // 5: backpressure with a second group queued behind the stalled result
    or0 = 1'b0;
    send(0, 32'd3, 32'd5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    send(0, 32'd7, 32'd6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("t5_valid", ov0, 1'b1);
    check_val("t5_result", res0, 48'd15);
    check_val("t5_rdy_low", rdy0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("t5_hold_valid", ov0, 1'b1);
      check_val("t5_hold_result", res0, 48'd15);
      check_val("t5_hold_rdy", rdy0, 1'b0);
    end
    @(negedge clk);
    a = 32'd2; b = 32'd3; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00;
    first = 1'b1; last = 1'b1; iv0 = 1'b1; or0 = 1'b1;
    #1;
    check_val("t5_rdy_release", rdy0, 1'b1);
    @(posedge clk); #1;
    iv0 = 1'b0;
    check_val("t5_next_valid", ov0, 1'b1);
    check_val("t5_next_result", res0, 48'd42);
    @(posedge clk); #1;
    check_val("t5_bubble", ov0, 1'b0);
    @(posedge clk); #1;
    check_val("t5_third_valid", ov0, 1'b1);
    check_val("t5_third_result", res0, 48'd6);

    // 6: 32-bit accumulator overflow, then reserved mode and reset mid-group
    send(1, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    send(1, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
`ifdef MAC_SAT_EN
    expect_out(1, "t6", 64'hFFFFFFFF, 1'b1);
`else
    expect_out(1, "t6", 64'hFFFC0002, 1'b1);
`endif
    check_val("t6_me_before", me1, 1'b0);
    send(1, 32'd3, 32'd2, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    check_val("t6_me_set", me1, 1'b1);
    send(1, 32'd3, 32'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check_val("t6_me_sticky", me1, 1'b1);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    check_val("t6_rst_ov", ov1, 1'b0);
    check_val("t6_rst_res", res1, 32'd0);
    check_val("t6_rst_ovf", ovf1, 1'b0);
    check_val("t6_rst_me", me1, 1'b0);
    check_val("t6_rst_rdy", rdy1, 1'b1);
    @(negedge clk);
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("t6_flushed", ov1, 1'b0);
    end
    send(1, 32'd5, 32'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_out(1, "t6_after_rst", 64'd35, 1'b0);
    check_val("t6_me_final", me1, 1'b0);
    check_val("me0_final", me0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
